// File: rtl/regfile_sb_pkg.sv
// Shared CPU package: default register-file geometry and architectural register indices.
package regfile_sb_pkg;

  localparam int unsigned CPU_AW = 5;
  localparam int unsigned CPU_DW = 32;
  localparam int unsigned R0_IDX = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-producer scoreboard: one bit per register plus a running count of pending bits.
module reg_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned AW = CPU_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] sa,
  input  logic          clr_en,
  input  logic [AW-1:0] ca,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic          busy0,
  output logic          busy1,
  output logic [AW:0]   busy_cnt
);

  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned CW   = AW + 1;

  logic [NREG-1:0] pend;
  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt_nxt;
  logic            inc;
  logic            dec;

  // Set is applied after clear so a new producer wins over the retiring one.
  always_comb begin
    pend_nxt = pend;
    if (clr_en) pend_nxt[ca] = 1'b0;
    if (set_en) pend_nxt[sa] = 1'b1;
    inc     = set_en && !pend[sa];
    dec     = clr_en && pend[ca] && !(set_en && (sa == ca));
    cnt_nxt = busy_cnt + CW'(inc) - CW'(dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  assign busy0 = pend[ra0];
  assign busy1 = pend[ra1];

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with write-bypass, optional hardwired r0 and a pending scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned AW      = CPU_AW,
  parameter int unsigned DW      = CPU_DW,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          sb_set,
  input  logic [AW-1:0] sb_sa,
  output logic          busy0,
  output logic          busy1,
  output logic [AW:0]   busy_cnt
);

  localparam int unsigned NREG = 1 << AW;
  localparam logic [AW-1:0] R0 = AW'(R0_IDX);

  logic [DW-1:0] regs [NREG];
  logic          w_ok;
  logic          s_ok;
  logic          r0_rd0;
  logic          r0_rd1;
  logic          sb_busy0;
  logic          sb_busy1;

  assign w_ok   = we && !((ZERO_R0 != 0) && (wa == R0));
  assign s_ok   = sb_set && !((ZERO_R0 != 0) && (sb_sa == R0));
  assign r0_rd0 = (ZERO_R0 != 0) && (ra0 == R0);
  assign r0_rd1 = (ZERO_R0 != 0) && (ra1 == R0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (w_ok) begin
      regs[wa] <= wd;
    end
  end

  // Bypass is suppressed in reset so the read ports read zero regardless of we/wd.
  always_comb begin
    rd0 = regs[ra0];
    rd1 = regs[ra1];
    if ((BYPASS != 0) && we) begin
      if (wa == ra0) rd0 = wd;
      if (wa == ra1) rd1 = wd;
    end
    if (r0_rd0) rd0 = '0;
    if (r0_rd1) rd1 = '0;
    if (!rst_n) begin
      rd0 = '0;
      rd1 = '0;
    end
  end

  reg_scoreboard #(.AW(AW)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (s_ok),
    .sa       (sb_sa),
    .clr_en   (w_ok),
    .ca       (wa),
    .ra0      (ra0),
    .ra1      (ra1),
    .busy0    (sb_busy0),
    .busy1    (sb_busy1),
    .busy_cnt (busy_cnt)
  );

  assign busy0 = sb_busy0 && !r0_rd0;
  assign busy1 = sb_busy1 && !r0_rd1;

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized + directed bench for regfile_sb against an array-based reference model (two configurations).
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we, sb_set;
  logic [AW-1:0] wa, sb_sa, ra0, ra1;
  logic [DW-1:0] wd;

  logic [DW-1:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic          a_busy0, a_busy1, b_busy0, b_busy1;
  logic [AW:0]   a_cnt, b_cnt;

  regfile_sb u_a (
    .clk(clk), .rst_n(rst_n), .ra0(ra0), .ra1(ra1), .rd0(a_rd0), .rd1(a_rd1),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_sa(sb_sa),
    .busy0(a_busy0), .busy1(a_busy1), .busy_cnt(a_cnt)
  );

  regfile_sb #(.ZERO_R0(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ra0(ra0), .ra1(ra1), .rd0(b_rd0), .rd1(b_rd1),
    .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_sa(sb_sa),
    .busy0(b_busy0), .busy1(b_busy1), .busy_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: config 0 = hardwired r0 + bypass, config 1 = neither.
  logic [DW-1:0] m_reg  [2][N];
  bit            m_pend [2][N];
  bit            zr [2] = '{1'b1, 1'b0};
  bit            by [2] = '{1'b1, 1'b0};

  task automatic m_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < N; i++) begin
        m_reg[c][i]  = '0;
        m_pend[c][i] = 1'b0;
      end
  endtask

  function automatic int m_cnt(input int c);
    int n = 0;
    for (int i = 0; i < N; i++) n += int'(m_pend[c][i]);
    return n;
  endfunction

  function automatic logic [DW-1:0] m_rd(input int c, input int ra);
    if (zr[c] && ra == 0) return '0;
    if (by[c] && we && int'(wa) == ra) return wd;
    return m_reg[c][ra];
  endfunction

  function automatic bit m_busy(input int c, input int ra);
    if (zr[c] && ra == 0) return 1'b0;
    return m_pend[c][ra];
  endfunction

  task automatic m_edge();
    for (int c = 0; c < 2; c++) begin
      if (we && !(zr[c] && wa == 0)) begin
        m_reg[c][wa]  = wd;
        m_pend[c][wa] = 1'b0;
      end
      if (sb_set && !(zr[c] && sb_sa == 0)) m_pend[c][sb_sa] = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("a.rd0",   64'(a_rd0),   64'(m_rd(0, int'(ra0))));
    chk("a.rd1",   64'(a_rd1),   64'(m_rd(0, int'(ra1))));
    chk("a.busy0", 64'(a_busy0), 64'(m_busy(0, int'(ra0))));
    chk("a.busy1", 64'(a_busy1), 64'(m_busy(0, int'(ra1))));
    chk("a.cnt",   64'(a_cnt),   64'(m_cnt(0)));
    chk("b.rd0",   64'(b_rd0),   64'(m_rd(1, int'(ra0))));
    chk("b.rd1",   64'(b_rd1),   64'(m_rd(1, int'(ra1))));
    chk("b.busy0", 64'(b_busy0), 64'(m_busy(1, int'(ra0))));
    chk("b.busy1", 64'(b_busy1), 64'(m_busy(1, int'(ra1))));
    chk("b.cnt",   64'(b_cnt),   64'(m_cnt(1)));
  endtask

  task automatic drive(input bit w, input int waddr, input logic [DW-1:0] wdata,
                       input bit s, input int saddr, input int r0, input int r1);
    we     = w;
    wa     = AW'(waddr);
    wd     = wdata;
    sb_set = s;
    sb_sa  = AW'(saddr);
    ra0    = AW'(r0);
    ra1    = AW'(r1);
  endtask

  // Called at posedge+1: present inputs, then check combinational/registered outputs mid-cycle.
  task automatic cyc(input bit w, input int waddr, input logic [DW-1:0] wdata,
                     input bit s, input int saddr, input int r0, input int r1);
    drive(w, waddr, wdata, s, saddr, r0, r1);
    #3;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic chk_reset_zero(input string tag);
    chk({tag, ".a.rd0"}, 64'(a_rd0), 64'd0);
    chk({tag, ".a.rd1"}, 64'(a_rd1), 64'd0);
    chk({tag, ".b.rd0"}, 64'(b_rd0), 64'd0);
    chk({tag, ".a.busy0"}, 64'(a_busy0), 64'd0);
    chk({tag, ".a.cnt"}, 64'(a_cnt), 64'd0);
    chk({tag, ".b.cnt"}, 64'(b_cnt), 64'd0);
  endtask

  int cnt_before;
  int w_r, wa_r, s_r, sa_r, r0_r, r1_r;

  initial begin
    m_reset();
    // Reset with active write/set/bypass traffic: everything must read zero.
    drive(1, 5, 32'hAAAA_5555, 1, 5, 5, 5);
    #2;
    chk_reset_zero("rst0");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, '0, 0, 0, 5, 5);
    tick();

    // Write r5, read it back next cycle, then async reset mid-cycle.
    cyc(1, 5, 32'h1234_5678, 0, 0, 0, 1);
    tick();
    cyc(0, 0, '0, 0, 0, 5, 1);
    chk("r5.a.rd0", 64'(a_rd0), 64'h1234_5678);
    tick();
    drive(1, 5, 32'hCAFE_F00D, 1, 6, 5, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_zero("rst1");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    cyc(0, 0, '0, 0, 0, 5, 6);
    tick();

    // Bypass: write r7 and read it in the same cycle.
    cyc(1, 7, 32'h1111_1111, 0, 0, 0, 0);
    tick();
    cyc(1, 7, 32'hDEAD_BEEF, 0, 0, 0, 7);
    chk("byp.a.rd1", 64'(a_rd1), 64'hDEAD_BEEF);
    chk("byp.b.rd1", 64'(b_rd1), 64'h1111_1111);
    tick();

    // r0 write and set are ignored when hardwired.
    cnt_before = int'(a_cnt);
    cyc(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
    chk("r0.a.rd0.byp", 64'(a_rd0), 64'd0);
    tick();
    cyc(0, 0, '0, 0, 0, 0, 0);
    chk("r0.a.rd0", 64'(a_rd0), 64'd0);
    chk("r0.a.busy0", 64'(a_busy0), 64'd0);
    chk("r0.a.cnt", 64'(a_cnt), 64'(cnt_before));
    tick();

    // Set r3 and r4, then retire r3.
    cyc(0, 0, '0, 1, 3, 3, 4);
    tick();
    cyc(0, 0, '0, 1, 4, 3, 4);
    tick();
    cyc(0, 0, '0, 0, 0, 3, 4);
    chk("sb.a.cnt2", 64'(a_cnt), 64'd2);
    chk("sb.a.busy3", 64'(a_busy0), 64'd1);
    chk("sb.a.busy4", 64'(a_busy1), 64'd1);
    tick();
    cyc(1, 3, 32'h3333_0003, 0, 0, 3, 4);
    tick();
    cyc(0, 0, '0, 0, 0, 3, 4);
    chk("sb.a.cnt1", 64'(a_cnt), 64'd1);
    chk("sb.a.busy3c", 64'(a_busy0), 64'd0);
    tick();

    // Set and write the same pending register: set wins, count unchanged.
    cyc(0, 0, '0, 1, 9, 9, 9);
    tick();
    cnt_before = int'(a_cnt);
    cyc(1, 9, 32'h9999_0009, 1, 9, 9, 9);
    tick();
    cyc(0, 0, '0, 0, 0, 9, 9);
    chk("sw.a.busy9", 64'(a_busy0), 64'd1);
    chk("sw.a.cnt", 64'(a_cnt), 64'(cnt_before));
    chk("sw.a.rd9", 64'(a_rd0), 64'h9999_0009);
    tick();

    // Fill the scoreboard, refill, then drain.
    for (int i = 1; i < N; i++) begin
      cyc(0, 0, '0, 1, i, i, 0);
      tick();
    end
    cyc(0, 0, '0, 0, 0, 1, 31);
    chk("fill.a.cnt", 64'(a_cnt), 64'd31);
    tick();
    for (int i = 1; i < N; i++) begin
      cyc(0, 0, '0, 1, i, i, 0);
      tick();
    end
    cyc(0, 0, '0, 0, 0, 1, 31);
    chk("refill.a.cnt", 64'(a_cnt), 64'd31);
    tick();
    for (int i = 1; i < N; i++) begin
      cyc(1, i, DW'($urandom), 0, 0, i, 0);
      tick();
    end
    cyc(0, 0, '0, 0, 0, 1, 31);
    chk("drain.a.cnt", 64'(a_cnt), 64'd0);
    tick();

    // Random traffic with biased address collisions.
    for (int k = 0; k < 600; k++) begin
      w_r  = int'($urandom_range(0, 1));
      s_r  = int'($urandom_range(0, 2) == 0);
      wa_r = int'($urandom_range(0, N - 1));
      sa_r = ($urandom_range(0, 3) == 0) ? wa_r : int'($urandom_range(0, N - 1));
      r0_r = ($urandom_range(0, 3) == 0) ? wa_r : int'($urandom_range(0, N - 1));
      r1_r = ($urandom_range(0, 3) == 0) ? sa_r : int'($urandom_range(0, N - 1));
      cyc(w_r[0], wa_r, DW'($urandom), s_r[0], sa_r, r0_r, r1_r);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
